// File: rtl/keypad_scanner.sv
// Passive key-matrix scanner: walks one active-low column at a time, debounces a single
// key on that column and reports it as col*ROWS+row with a one-cycle valid pulse.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 5000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row_n,
    output logic [COLS-1:0] col_n,
    output logic [4:0]      key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int NW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t          state, state_d;
    logic [ROWS-1:0] rs_meta, rs, low;
    logic [DW-1:0]   div;
    logic            sample, hit, match, do_accept, do_release;
    logic [CW-1:0]   col, col_d, col_next;
    logic [RW-1:0]   cand, cand_d, hit_row;
    logic [NW-1:0]   cnt, cnt_d;
    logic [4:0]      code_d;
    logic            valid_d, held_d;

    assign sample   = (div == DW'(SCAN_DIV - 1));
    assign low      = ~rs;
    // Exactly one low row is a hit; several low rows (ghosting) count as empty.
    assign hit      = (low != '0) && ((low & (low - 1'b1)) == '0);
    assign match    = hit && (hit_row == cand);
    assign col_next = (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
    assign col_n    = ~(COLS'(1) << col);

    always_comb begin
        hit_row = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (!rs[i]) hit_row = RW'(i);
        end
    end

    always_comb begin
        state_d    = state;
        col_d      = col;
        cand_d     = cand;
        cnt_d      = cnt;
        code_d     = key_code;
        valid_d    = 1'b0;
        held_d     = key_held;
        do_accept  = 1'b0;
        do_release = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (hit) begin
                        cand_d = hit_row;
                        if (DEBOUNCE_CNT == 1) begin
                            do_accept = 1'b1;
                        end else begin
                            cnt_d   = NW'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_d = col_next;
                    end
                end
                DEBOUNCE: begin
                    if (match) begin
                        if (cnt == NW'(DEBOUNCE_CNT - 1)) do_accept = 1'b1;
                        else                              cnt_d = cnt + 1'b1;
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_next;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!match) begin
                        if (DEBOUNCE_CNT == 1 && !hit) begin
                            do_release = 1'b1;
                        end else begin
                            cnt_d   = NW'(1);
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (match) begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end else if (hit) begin
                        cnt_d = '0;
                    end else if (cnt == NW'(DEBOUNCE_CNT - 1)) begin
                        do_release = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
        if (do_accept) begin
            code_d  = 5'(col) * 5'(ROWS) + 5'(hit_row);
            valid_d = 1'b1;
            held_d  = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
        end
        if (do_release) begin
            held_d  = 1'b0;
            cnt_d   = '0;
            col_d   = col_next;
            state_d = SCAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_meta   <= '1;
            rs        <= '1;
            div       <= '0;
            state     <= SCAN;
            col       <= '0;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            rs_meta   <= row_n;
            rs        <= rs_meta;
            div       <= sample ? '0 : div + 1'b1;
            state     <= state_d;
            col       <= col_d;
            cand      <= cand_d;
            cnt       <= cnt_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end
    end

endmodule
